vec_alu_sequencer: RTL and testbench

- Upstream issue stage for the single-lane ALU in the vector CPU.
- Accepts one vector instruction: 4-bit vector opcode, two packed vectors and one scalar.
- Translates the opcode to the single-ALU control code and walks the vector lanes through one ALU instance, one lane per cycle.
- Assembles the result vector and aggregate flags, then presents them downstream with a valid/ready handshake.

---
 rtl/vec_alu_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_vec_alu_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_alu_sequencer.sv
// Vector issue stage: walks LANES elements through one external ALU.
// Optional VEC_LANE_MASK_EN adds a per-lane enable mask latched at accept.
module vec_alu_sequencer #(
    parameter int N     = 8,
    parameter int LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_op,
    input  logic [N*LANES-1:0]   in_va,
    input  logic [N*LANES-1:0]   in_vb,
    input  logic [N-1:0]         in_scalar,
`ifdef VEC_LANE_MASK_EN
    input  logic [LANES-1:0]     in_mask,
`endif
    output logic [N-1:0]         alu_a,
    output logic [N-1:0]         alu_b,
    output logic [3:0]           alu_ctrl,
    input  logic [N-1:0]         alu_y,
    input  logic [3:0]           alu_flags,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*LANES-1:0]   out_vec,
    output logic [LANES-1:0]     out_zero_mask,
    output logic                 out_carry_any,
    output logic                 out_ovf_any,
    output logic                 out_err
);

    localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [1:0] {P_VV, P_VS, P_SH} pair_t;

    state_t             state;
    state_t             state_d;
    logic [IW-1:0]      idx;
    logic [3:0]         ctrl_q;
    pair_t              pair_q;
    logic [N*LANES-1:0] va_q;
    logic [N*LANES-1:0] vb_q;
    logic [N-1:0]       sc_q;
    logic [N*LANES-1:0] vec_q;
    logic [LANES-1:0]   zm_q;
    logic               c_q;
    logic               v_q;
    logic               err_q;

    logic [3:0]         dec_ctrl;
    pair_t              dec_pair;
    logic               dec_err;
    logic [N-1:0]       lane_a;
    logic [N-1:0]       lane_b;
    logic               idx_last;
    logic               lane_en;
    logic               arith;
    logic               flags_unused;

    // Negative flag has no aggregate output
    assign flags_unused = alu_flags[3];

`ifdef VEC_LANE_MASK_EN
    logic [LANES-1:0]   mask_q;
    assign lane_en = mask_q[idx];
`else
    assign lane_en = 1'b1;
`endif

    assign lane_a   = va_q[int'(idx)*N +: N];
    assign lane_b   = vb_q[int'(idx)*N +: N];
    assign idx_last = (idx == IW'(LANES-1));
    assign arith    = (ctrl_q == 4'd0) || (ctrl_q == 4'd1);

    always_comb begin
        dec_ctrl = 4'd0;
        dec_pair = P_VV;
        dec_err  = 1'b0;
        case (in_op)
            4'b0000: begin dec_ctrl = 4'd2;  dec_pair = P_VS; end
            4'b0001: begin dec_ctrl = 4'd2;  dec_pair = P_VV; end
            4'b0010: begin dec_ctrl = 4'd3;  dec_pair = P_VS; end
            4'b0011: begin dec_ctrl = 4'd3;  dec_pair = P_VV; end
            4'b0100: begin dec_ctrl = 4'd5;  dec_pair = P_VS; end
            4'b0101: begin dec_ctrl = 4'd5;  dec_pair = P_VV; end
            4'b0110: begin dec_ctrl = 4'd7;  dec_pair = P_SH; end
            4'b0111: begin dec_ctrl = 4'd6;  dec_pair = P_SH; end
            4'b1000: begin dec_ctrl = 4'd10; dec_pair = P_SH; end
            4'b1001: begin dec_ctrl = 4'd9;  dec_pair = P_SH; end
            4'b1010: begin dec_ctrl = 4'd0;  dec_pair = P_VV; end
            4'b1011: begin dec_ctrl = 4'd0;  dec_pair = P_VS; end
            4'b1100: begin dec_ctrl = 4'd1;  dec_pair = P_VV; end
            4'b1101: begin dec_ctrl = 4'd1;  dec_pair = P_VS; end
            default: dec_err = 1'b1;
        endcase
    end

    // ALU is only driven while lanes are being walked
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = '0;
        if (state == RUN) begin
            alu_ctrl = ctrl_q;
            case (pair_q)
                P_VS: begin alu_a = lane_a; alu_b = sc_q; end
                P_SH: begin alu_a = sc_q;   alu_b = lane_a; end
                default: begin alu_a = lane_a; alu_b = lane_b; end
            endcase
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (in_valid) state_d = dec_err ? DONE : RUN;
            RUN:  if (idx_last) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            ctrl_q <= '0;
            pair_q <= P_VV;
            va_q   <= '0;
            vb_q   <= '0;
            sc_q   <= '0;
            vec_q  <= '0;
            zm_q   <= '0;
            c_q    <= 1'b0;
            v_q    <= 1'b0;
            err_q  <= 1'b0;
`ifdef VEC_LANE_MASK_EN
            mask_q <= '0;
`endif
        end else begin
            state <= state_d;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ctrl_q <= dec_ctrl;
                        pair_q <= dec_pair;
                        va_q   <= in_va;
                        vb_q   <= in_vb;
                        sc_q   <= in_scalar;
                        vec_q  <= '0;
                        zm_q   <= '0;
                        c_q    <= 1'b0;
                        v_q    <= 1'b0;
                        err_q  <= dec_err;
                        idx    <= '0;
`ifdef VEC_LANE_MASK_EN
                        mask_q <= in_mask;
`endif
                    end
                end
                RUN: begin
                    if (lane_en) begin
                        vec_q[int'(idx)*N +: N] <= alu_y;
                        zm_q[idx] <= alu_flags[2];
                        if (arith) begin
                            c_q <= c_q | alu_flags[1];
                            v_q <= v_q | alu_flags[0];
                        end
                    end else begin
                        vec_q[int'(idx)*N +: N] <= lane_a;
                        zm_q[idx] <= 1'b0;
                    end
                    idx <= idx_last ? '0 : idx + 1'b1;
                end
                DONE: begin
                    if (out_ready) err_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready      = (state == IDLE);
    assign out_valid     = (state == DONE);
    assign out_vec       = vec_q;
    assign out_zero_mask = zm_q;
    assign out_carry_any = c_q;
    assign out_ovf_any   = v_q;
    assign out_err       = err_q;

endmodule

// File: tb/tb_vec_alu_sequencer.sv
// Directed bench for vec_alu_sequencer with a behavioural 8-bit ALU.
module tb_vec_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = '0;
    logic [31:0] in_va = '0;
    logic [31:0] in_vb = '0;
    logic [7:0]  in_scalar = '0;
`ifdef VEC_LANE_MASK_EN
    logic [3:0]  in_mask = 4'hF;
`endif
    logic [7:0]  alu_a, alu_b, alu_y;
    logic [3:0]  alu_ctrl, alu_flags;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_vec;
    logic [3:0]  out_zero_mask;
    logic        out_carry_any, out_ovf_any, out_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    vec_alu_sequencer #(.N(8), .LANES(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_va(in_va), .in_vb(in_vb),
        .in_scalar(in_scalar),
`ifdef VEC_LANE_MASK_EN
        .in_mask(in_mask),
`endif
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_y(alu_y), .alu_flags(alu_flags),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_vec(out_vec), .out_zero_mask(out_zero_mask),
        .out_carry_any(out_carry_any), .out_ovf_any(out_ovf_any),
        .out_err(out_err)
    );

    // Reference ALU; shifts/logic report a junk carry that must be ignored
    logic [8:0] sum;
    logic [2:0] amt;
    logic       fc, fv;
    always_comb begin
        sum   = '0;
        alu_y = '0;
        fc    = 1'b0;
        fv    = 1'b0;
        amt   = alu_a[2:0];
        case (alu_ctrl)
            4'd0: begin
                sum   = {1'b0, alu_a} + {1'b0, alu_b};
                alu_y = sum[7:0];
                fc    = sum[8];
                fv    = (alu_a[7] == alu_b[7]) && (alu_y[7] != alu_a[7]);
            end
            4'd1: begin
                alu_y = alu_a - alu_b;
                fc    = alu_a < alu_b;
                fv    = (alu_a[7] != alu_b[7]) && (alu_y[7] != alu_a[7]);
            end
            4'd2: begin alu_y = alu_a & alu_b; fc = 1'b1; fv = 1'b1; end
            4'd3: begin alu_y = alu_a | alu_b; fc = 1'b1; fv = 1'b1; end
            4'd5: begin alu_y = alu_a ^ alu_b; fc = 1'b1; fv = 1'b1; end
            4'd6: begin alu_y = alu_b << amt; fc = 1'b1; end
            4'd7: begin alu_y = alu_b >> amt; fc = 1'b1; end
            4'd9: begin
                alu_y = (alu_b << amt) | (alu_b >> (4'd8 - {1'b0, amt}));
                fc    = alu_y[0];
                fv    = 1'b1;
            end
            4'd10: begin
                alu_y = (alu_b >> amt) | (alu_b << (4'd8 - {1'b0, amt}));
                fc    = alu_y[7];
                fv    = 1'b1;
            end
            default: ;
        endcase
        alu_flags = {alu_y[7], alu_y == 8'h00, fc, fv};
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] va;
        logic [31:0] vb;
        logic [7:0]  sc;
        logic [31:0] vec;
        logic [3:0]  zm;
        logic        c;
        logic        v;
        logic        err;
        int          lat;
    } vec_t;

    localparam int NV = 15;
    vec_t tv [NV];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic issue(input vec_t t, output int lat);
        @(negedge clk);
        in_valid  = 1'b1;
        in_op     = t.op;
        in_va     = t.va;
        in_vb     = t.vb;
        in_scalar = t.sc;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic ack();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("ack_valid", {31'd0, out_valid}, 32'd0);
        chk("ack_ready", {31'd0, in_ready}, 32'd1);
        chk("ack_err", {31'd0, out_err}, 32'd0);
    endtask

    task automatic run_vec(input vec_t t, input string tag);
        int lat;
        issue(t, lat);
        chk({tag, "_lat"}, lat, t.lat);
        chk({tag, "_vec"}, out_vec, t.vec);
        chk({tag, "_zm"}, {28'd0, out_zero_mask}, {28'd0, t.zm});
        chk({tag, "_c"}, {31'd0, out_carry_any}, {31'd0, t.c});
        chk({tag, "_v"}, {31'd0, out_ovf_any}, {31'd0, t.v});
        chk({tag, "_err"}, {31'd0, out_err}, {31'd0, t.err});
        chk({tag, "_aluz"}, {12'd0, alu_ctrl, alu_a, alu_b}, 32'd0);
        ack();
        chk({tag, "_hold"}, out_vec, t.vec);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        tv[0]  = '{4'hA, 32'hFF7F0201, 32'h01010301, 8'h00,
                   32'h00800502, 4'b1000, 1'b1, 1'b1, 1'b0, 4};
        tv[1]  = '{4'hD, 32'h03030005, 32'h0, 8'h03,
                   32'h0000FD02, 4'b1100, 1'b1, 1'b0, 1'b0, 4};
        tv[2]  = '{4'h7, 32'h810140FF, 32'h0, 8'h02,
                   32'h040400FC, 4'b0010, 1'b0, 1'b0, 1'b0, 4};
        tv[3]  = '{4'h9, 32'h81800001, 32'h0, 8'h01,
                   32'h03010002, 4'b0010, 1'b0, 1'b0, 1'b0, 4};
        tv[4]  = '{4'h0, 32'hF00FAA55, 32'h0, 8'h0F,
                   32'h000F0A05, 4'b1000, 1'b0, 1'b0, 1'b0, 4};
        tv[5]  = '{4'h5, 32'h12345678, 32'h1200FF0F, 8'h00,
                   32'h0034A977, 4'b1000, 1'b0, 1'b0, 1'b0, 4};
        tv[6]  = '{4'h3, 32'h00018000, 32'h00100100, 8'h00,
                   32'h00118100, 4'b1001, 1'b0, 1'b0, 1'b0, 4};
        tv[7]  = '{4'h6, 32'h8001FE02, 32'h0, 8'h09,
                   32'h40007F01, 4'b0100, 1'b0, 1'b0, 1'b0, 4};
        tv[8]  = '{4'h8, 32'h12F00100, 32'h0, 8'h04,
                   32'h210F1000, 4'b0001, 1'b0, 1'b0, 1'b0, 4};
        tv[9]  = '{4'hC, 32'h80100500, 32'h01100300, 8'h00,
                   32'h7F000200, 4'b0101, 1'b0, 1'b1, 1'b0, 4};
        tv[10] = '{4'h2, 32'h00000001, 32'h0, 8'h00,
                   32'h00000001, 4'b1110, 1'b0, 1'b0, 1'b0, 4};
        tv[11] = '{4'h4, 32'hFF000F3C, 32'h0, 8'hFF,
                   32'h00FFF0C3, 4'b1000, 1'b0, 1'b0, 1'b0, 4};
        tv[12] = '{4'hB, 32'h007F80FF, 32'h0, 8'h80,
                   32'h80FF007F, 4'b0010, 1'b1, 1'b1, 1'b0, 4};
        tv[13] = '{4'h1, 32'hFFFF00AA, 32'h0F00FFAA, 8'h00,
                   32'h0F0000AA, 4'b0110, 1'b0, 1'b0, 1'b0, 4};
        tv[14] = '{4'hF, 32'h11223344, 32'h55667788, 8'h01,
                   32'h0, 4'b0000, 1'b0, 1'b0, 1'b1, 0};

        #12;
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_vec", out_vec, 32'd0);
        chk("rst_flags", {27'd0, out_zero_mask, out_carry_any},
            32'd0);
        chk("rst_alu", {12'd0, alu_ctrl, alu_a, alu_b}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run_vec(tv[i], $sformatf("v%0d", i));
        end

        // Illegal op held in DONE under backpressure
        begin
            vec_t t;
            int lat;
            t = tv[14];
            t.op = 4'hE;
            issue(t, lat);
            chk("ill_lat", lat, 0);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                in_valid = 1'b1;
                in_op    = tv[0].op;
                in_va    = tv[0].va;
                in_vb    = tv[0].vb;
                @(posedge clk);
                #1;
                chk("ill_valid", {31'd0, out_valid}, 32'd1);
                chk("ill_ready", {31'd0, in_ready}, 32'd0);
                chk("ill_err", {31'd0, out_err}, 32'd1);
                chk("ill_vec", out_vec, 32'd0);
            end
            in_valid = 1'b0;
            ack();
            @(posedge clk);
            #1;
            chk("ill_nottaken", {31'd0, in_ready}, 32'd1);
            chk("ill_vec_after", out_vec, 32'd0);
        end

        // Reset while lane 2 is on the ALU
        @(negedge clk);
        in_valid  = 1'b1;
        in_op     = tv[0].op;
        in_va     = tv[0].va;
        in_vb     = tv[0].vb;
        in_scalar = tv[0].sc;
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("run_ready", {31'd0, in_ready}, 32'd0);
        chk("run_lane0", {24'd0, alu_a}, 32'h01);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("run_lane2", {24'd0, alu_a}, 32'h7F);
        #2 rst = 1'b1;
        #1;
        chk("arst_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_vec", out_vec, 32'd0);
        chk("arst_alu", {12'd0, alu_ctrl, alu_a, alu_b}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(tv[0], "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
